egress: RTL and testbench
=========================

EGRESS -- requirements
Module: egress

Interface
REQ-001 Parameter FIFO_DEPTH, default 64, sets the egress record FIFO depth in entries; it SHALL be a power of two.
REQ-002 Parameter META_WIDTH, default 32, sets the metadata word width in bits.
REQ-003 Port clk, input, 1 bit, is the single clock; all logic SHALL be rising-edge.
REQ-004 Port reset, input, 1 bit, is the synchronous active-high reset.
REQ-005 Port egress_in, input, META_WIDTH bits, is the crossbar word {src[31:30], dst[29:28], payload tag[27:22], enq_ts[21:11], deq_ts[10:0]}.
REQ-006 Port egress_in_en, input, 1 bit, marks egress_in valid in the current cycle.
REQ-007 Port experimenting, input, 1 bit, is the run enable from software.
REQ-008 Port time_stamp, input, 11 bits, is the free-running switch time.
REQ-009 Port egress_rd_en, input, 1 bit, is the software read strobe, one pop per cycle high.
REQ-010 Port egress_out, output, 32 bits, is the head record.
REQ-011 Port egress_out_valid, output, 1 bit, is high when egress_out holds an unread record.
REQ-012 Port drop_cnt, output, 16 bits, counts arrivals lost to a full FIFO.
REQ-013 Port rx_cnt, output, 16 bits, counts records written.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-015 The FSM SHALL transition IDLE->RUN on experimenting=1, RUN->HOLD on experimenting=0, HOLD->RUN on experimenting=1, and SHALL never return to IDLE except via reset.
REQ-016 On IDLE->RUN and on HOLD->RUN, the FIFO, rx_cnt and drop_cnt SHALL clear in the transition cycle.
REQ-017 In IDLE and HOLD, egress_in_en SHALL be ignored; reads SHALL be allowed in every state.
REQ-018 The input stage SHALL register the arrival in 1 cycle.
REQ-019 The record SHALL be {egress_in[31:22], lat[10:0], qd[10:0]} with lat = time_stamp_at_arrival - enq_ts and qd = deq_ts - enq_ts, both computed mod 2^11.
REQ-020 The record SHALL be written to the FIFO in the cycle after arrival, giving 2 cycles from arrival to egress_out_valid when the FIFO is empty.
REQ-021 An arrival with the FIFO full at its write cycle SHALL be discarded and SHALL increment drop_cnt.
REQ-022 A simultaneous pop and push on a full FIFO SHALL succeed without a drop.
REQ-023 egress_out SHALL show the head record (first-word fall-through); egress_rd_en advances the head on the next edge.
REQ-024 egress_rd_en while egress_out_valid=0 SHALL have no effect.
REQ-025 rx_cnt and drop_cnt SHALL saturate at 16'hFFFF.
REQ-026 Timestamp wrap SHALL need no special case: enq_ts=2040 with arrival at 5 gives lat=13.

Reset
REQ-027 Reset SHALL force the FSM to IDLE, the FIFO pointers to 0, egress_out_valid=0, egress_out=0, rx_cnt=0, drop_cnt=0, and clear the input-stage valid.
REQ-028 Reset asserted mid-write SHALL discard the in-flight record.

Configuration
REQ-029 With EGRESS_SRC_STATS_EN defined, the block SHALL add output src_cnt[4][16] (per-src saturating write counts) and max_lat[11] (largest lat written), both cleared with rx_cnt.
REQ-030 Without EGRESS_SRC_STATS_EN, those ports and their registers SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package switch_pkg SHALL hold the metadata field bit positions, the TS_WIDTH=11 constant and the egress FSM state enum.
REQ-032 Sub-module egress_fifo SHALL be a synchronous FWFT FIFO providing full/empty and one push plus one pop per cycle.

Verification
REQ-033 Reset, set experimenting=1, at time 100 send enq_ts=90, deq_ts=95 -> at cycle +2 egress_out_valid=1, lat=10, qd=5, rx_cnt=1.
REQ-034 Send enq_ts=2040 arriving at time_stamp=5 -> lat=13.
REQ-035 Send 66 back-to-back arrivals with no reads -> rx_cnt=64, drop_cnt=2; 64 reads then give egress_out_valid=0.
REQ-036 With the FIFO full, hold egress_in_en and egress_rd_en together for 10 cycles -> drop_cnt stays unchanged.
REQ-037 Drop experimenting to 0, send 5 arrivals -> rx_cnt unchanged; raise experimenting again -> counters and FIFO cleared.
REQ-038 With EGRESS_SRC_STATS_EN defined, send 3 arrivals with src=2 and lats 4, 9, 7 -> src_cnt[2]=3, max_lat=9.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared switch definitions: crossbar metadata field positions, timestamp
// width, and the egress FSM state encoding.
package switch_pkg;
  localparam int TS_WIDTH  = 11;
  localparam int REC_WIDTH = 32;

  // Crossbar word {src, dst, tag, enq_ts, deq_ts}
  localparam int SRC_HI = 31, SRC_LO = 30;
  localparam int DST_HI = 29, DST_LO = 28;
  localparam int TAG_HI = 27, TAG_LO = 22;
  localparam int ENQ_HI = 21, ENQ_LO = 11;
  localparam int DEQ_HI = 10, DEQ_LO = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} egress_state_e;

  // Modular difference; wrap of the free-running clock falls out naturally.
  function automatic logic [TS_WIDTH-1:0] ts_diff(input logic [TS_WIDTH-1:0] a,
                                                  input logic [TS_WIDTH-1:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/egress_if.sv
// Egress data path bundle.
//   egress_in/egress_in_en : crossbar word and its valid (master -> egress)
//   egress_rd_en           : software pop strobe (master -> egress)
//   egress_out/_valid      : FWFT head record (egress -> master)
interface egress_if #(parameter int META_WIDTH = 32);
  logic [META_WIDTH-1:0] egress_in;
  logic                  egress_in_en;
  logic                  egress_rd_en;
  logic [31:0]           egress_out;
  logic                  egress_out_valid;

  modport master (output egress_in, egress_in_en, egress_rd_en,
                  input  egress_out, egress_out_valid);
  modport slave  (input  egress_in, egress_in_en, egress_rd_en,
                  output egress_out, egress_out_valid);
endinterface

// File: rtl/egress_fifo.sv
// Synchronous first-word-fall-through FIFO, one push and one pop per cycle.
//   clk, reset : clock, sync active-high reset
//   clr        : synchronous flush (empties the FIFO)
//   push/din   : write request and data; ignored when full unless popping
//   pop        : advance head; ignored when empty
//   dout       : head entry (0 when empty); full/empty flags
module egress_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty && !clr;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok) && !clr;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/egress.sv
// Egress record builder: stamps crossbar arrivals with latency and queueing
// delay, buffers records in an FWFT FIFO for software, counts writes/drops.
//   clk, reset     : clock, sync active-high reset
//   bus (slave)    : egress_in/_en in, egress_rd_en in, egress_out/_valid out
//   experimenting  : software run enable (IDLE->RUN, RUN<->HOLD)
//   time_stamp     : free-running switch time
//   rx_cnt/drop_cnt: saturating written / dropped record counts
// Optional EGRESS_SRC_STATS_EN: adds src_cnt[4] per-source write counts and
// max_lat (largest written latency), cleared together with rx_cnt.
module egress
  import switch_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int META_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  egress_if.slave             bus,
  input  logic                experimenting,
  input  logic [TS_WIDTH-1:0] time_stamp,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         rx_cnt
`ifdef EGRESS_SRC_STATS_EN
  ,
  output logic [3:0][15:0]    src_cnt,
  output logic [TS_WIDTH-1:0] max_lat
`endif
);
  egress_state_e state, state_nxt;
  logic accept, clr;

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (experimenting)  state_nxt = ST_RUN;
      ST_RUN:  if (!experimenting) state_nxt = ST_HOLD;
      ST_HOLD: if (experimenting)  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // clr fires on every entry into RUN.
  always_comb begin
    accept = (state == ST_RUN);
    clr    = (state != ST_RUN) && experimenting;
  end

  // ---- input stage: latency is taken against arrival-time clock ----
  logic                 stage_vld;
  logic [REC_WIDTH-1:0] stage_rec, rec_d;
  logic [TS_WIDTH-1:0]  enq_ts, deq_ts;

  assign enq_ts = bus.egress_in[ENQ_HI:ENQ_LO];
  assign deq_ts = bus.egress_in[DEQ_HI:DEQ_LO];
  assign rec_d  = {bus.egress_in[SRC_HI:TAG_LO],
                   ts_diff(time_stamp, enq_ts),
                   ts_diff(deq_ts, enq_ts)};

  always_ff @(posedge clk) begin
    if (reset || clr) stage_vld <= 1'b0;
    else              stage_vld <= bus.egress_in_en && accept;
  end

  always_ff @(posedge clk) begin
    if (bus.egress_in_en && accept) stage_rec <= rec_d;
  end

  // ---- FIFO write / drop decision ----
  logic fifo_full, fifo_empty, wr, drop;
  logic [REC_WIDTH-1:0] fifo_dout;

  // Full FIFO with a pending pop (head is valid since full) still accepts.
  assign drop = stage_vld && !clr && fifo_full && !bus.egress_rd_en;
  assign wr   = stage_vld && !clr && !drop;

  egress_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REC_WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (wr),
    .pop   (bus.egress_rd_en),
    .din   (stage_rec),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.egress_out       = fifo_dout;
  assign bus.egress_out_valid = !fifo_empty;

  // ---- saturating counters ----
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr   && rx_cnt   != 16'hFFFF) rx_cnt   <= rx_cnt + 16'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef EGRESS_SRC_STATS_EN
  logic [1:0]          wr_src;
  logic [TS_WIDTH-1:0] wr_lat;
  assign wr_src = stage_rec[SRC_HI:SRC_LO];
  assign wr_lat = stage_rec[2*TS_WIDTH-1:TS_WIDTH];

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      src_cnt <= '0;
      max_lat <= '0;
    end else if (wr) begin
      if (src_cnt[wr_src] != 16'hFFFF) src_cnt[wr_src] <= src_cnt[wr_src] + 16'd1;
      if (wr_lat > max_lat) max_lat <= wr_lat;
    end
  end
`endif
endmodule

// File: tb/tb_egress.sv
module tb_egress;
  import switch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        experimenting = 1'b0;
  logic [10:0] time_stamp = '0;
  logic [15:0] drop_cnt, rx_cnt;
`ifdef EGRESS_SRC_STATS_EN
  logic [3:0][15:0] src_cnt;
  logic [10:0]      max_lat;
`endif

  egress_if #(.META_WIDTH(32)) bus ();

  egress #(.FIFO_DEPTH(64), .META_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .experimenting (experimenting),
    .time_stamp    (time_stamp),
    .drop_cnt      (drop_cnt),
    .rx_cnt        (rx_cnt)
`ifdef EGRESS_SRC_STATS_EN
    ,
    .src_cnt       (src_cnt),
    .max_lat       (max_lat)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] word(input logic [1:0] src, input logic [1:0] dst,
                                       input logic [5:0] tag, input logic [10:0] enq,
                                       input logic [10:0] deq);
    return {src, dst, tag, enq, deq};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.egress_in    = '0;
    bus.egress_in_en = 1'b0;
    bus.egress_rd_en = 1'b0;

    // Reset state
    step(2);
    check("rst_valid", {31'd0, bus.egress_out_valid}, 32'd0);
    check("rst_out",   bus.egress_out, 32'd0);
    check("rst_rx",    {16'd0, rx_cnt}, 32'd0);
    check("rst_drop",  {16'd0, drop_cnt}, 32'd0);

    // Basic record: arrival at 100, enq 90, deq 95 -> lat 10, qd 5
    reset = 1'b0;
    experimenting = 1'b1;
    step();                                   // IDLE -> RUN
    bus.egress_in    = word(2'd1, 2'd2, 6'h15, 11'd90, 11'd95);
    bus.egress_in_en = 1'b1;
    time_stamp       = 11'd100;
    step();
    bus.egress_in_en = 1'b0;
    check("lat1_valid", {31'd0, bus.egress_out_valid}, 32'd0);
    step();
    check("lat2_valid", {31'd0, bus.egress_out_valid}, 32'd1);
    check("rec_basic",  bus.egress_out, {2'd1, 2'd2, 6'h15, 11'd10, 11'd5});
    check("rx_one",     {16'd0, rx_cnt}, 32'd1);

    // Pop, then a read while empty does nothing
    bus.egress_rd_en = 1'b1;
    step();
    check("pop_empty", {31'd0, bus.egress_out_valid}, 32'd0);
    step();
    bus.egress_rd_en = 1'b0;
    check("rd_empty_valid", {31'd0, bus.egress_out_valid}, 32'd0);
    check("rd_empty_rx",    {16'd0, rx_cnt}, 32'd1);

    // Timestamp wrap: enq 2040, arrival 5 -> lat 13, deq 2045 -> qd 5
    bus.egress_in    = word(2'd3, 2'd0, 6'h2A, 11'd2040, 11'd2045);
    bus.egress_in_en = 1'b1;
    time_stamp       = 11'd5;
    step();
    bus.egress_in_en = 1'b0;
    step();
    check("rec_wrap", bus.egress_out, {2'd3, 2'd0, 6'h2A, 11'd13, 11'd5});
    bus.egress_rd_en = 1'b1;
    step();
    bus.egress_rd_en = 1'b0;

    // HOLD -> RUN clears counters
    experimenting = 1'b0;
    step();
    experimenting = 1'b1;
    step();
    check("clr_rx", {16'd0, rx_cnt}, 32'd0);

    // 66 back-to-back arrivals, no reads
    time_stamp = 11'd0;
    bus.egress_in_en = 1'b1;
    for (int i = 0; i < 66; i++) begin
      bus.egress_in = word(2'd0, 2'd0, 6'(i), 11'd0, 11'd0);
      step();
    end
    bus.egress_in_en = 1'b0;
    step();
    check("fill_rx",   {16'd0, rx_cnt}, 32'd64);
    check("fill_drop", {16'd0, drop_cnt}, 32'd2);
    check("fill_head", bus.egress_out, 32'd0);

    // Full FIFO, push and pop together for 10 cycles: no new drops
    bus.egress_in    = word(2'd0, 2'd0, 6'h3F, 11'd0, 11'd0);
    bus.egress_in_en = 1'b1;
    bus.egress_rd_en = 1'b1;
    step(10);
    bus.egress_in_en = 1'b0;
    bus.egress_rd_en = 1'b0;
    step();
    check("pp_drop", {16'd0, drop_cnt}, 32'd2);
    check("pp_rx",   {16'd0, rx_cnt}, 32'd74);
    check("pp_head", bus.egress_out, {10'd10, 22'd0});

    // Drain 64 entries
    bus.egress_rd_en = 1'b1;
    step(64);
    bus.egress_rd_en = 1'b0;
    check("drain_valid", {31'd0, bus.egress_out_valid}, 32'd0);
    check("drain_out",   bus.egress_out, 32'd0);

    // Leave one record, then HOLD ignores arrivals
    bus.egress_in    = word(2'd2, 2'd1, 6'h01, 11'd0, 11'd0);
    bus.egress_in_en = 1'b1;
    step();
    bus.egress_in_en = 1'b0;
    step();
    check("pre_hold_rx", {16'd0, rx_cnt}, 32'd75);
    experimenting = 1'b0;
    step();
    bus.egress_in_en = 1'b1;
    step(5);
    bus.egress_in_en = 1'b0;
    step(2);
    check("hold_rx",    {16'd0, rx_cnt}, 32'd75);
    check("hold_valid", {31'd0, bus.egress_out_valid}, 32'd1);
    experimenting = 1'b1;
    step();
    check("rerun_rx",    {16'd0, rx_cnt}, 32'd0);
    check("rerun_drop",  {16'd0, drop_cnt}, 32'd0);
    check("rerun_valid", {31'd0, bus.egress_out_valid}, 32'd0);

    // Reset while a record sits in the input stage discards it
    bus.egress_in    = word(2'd1, 2'd1, 6'h05, 11'd0, 11'd0);
    bus.egress_in_en = 1'b1;
    step();
    bus.egress_in_en = 1'b0;
    reset = 1'b1;
    experimenting = 1'b0;
    step();
    reset = 1'b0;
    step(2);
    check("rstmid_valid", {31'd0, bus.egress_out_valid}, 32'd0);
    check("rstmid_rx",    {16'd0, rx_cnt}, 32'd0);

`ifdef EGRESS_SRC_STATS_EN
    // src=2 arrivals at time 10 with lats 4, 9, 7
    experimenting = 1'b1;
    step();
    time_stamp       = 11'd10;
    bus.egress_in_en = 1'b1;
    bus.egress_in    = word(2'd2, 2'd0, 6'h0, 11'd6, 11'd6);
    step();
    bus.egress_in    = word(2'd2, 2'd0, 6'h0, 11'd1, 11'd1);
    step();
    bus.egress_in    = word(2'd2, 2'd0, 6'h0, 11'd3, 11'd3);
    step();
    bus.egress_in_en = 1'b0;
    step();
    check("src_cnt2", {16'd0, src_cnt[2]}, 32'd3);
    check("src_cnt0", {16'd0, src_cnt[0]}, 32'd0);
    check("max_lat",  {21'd0, max_lat}, 32'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
